booth_seq_divider: RTL

//  Signed two's-complement sequential divider (restoring, radix-2): inverse datapath to the
//  16-bit Booth/Wallace multiplier. Accepts dividend/divisor over valid/ready, iterates one

---
 rtl/booth_seq_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/booth_seq_divider.sv
// Signed restoring radix-2 sequential divider: one quotient bit per clock over
// magnitudes, signs re-applied at the end. valid/ready on both sides, no overlap.
`timescale 1ns/1ps
module booth_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CALC, SIGN, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] dvd_q, dvs_q;
  logic [WIDTH-1:0]        acc, qr, dvs_mag;
  logic                    sign_q, sign_r;
  logic [CW-1:0]           count;
  logic [WIDTH:0]          shl, trial;

  // Magnitude as unsigned; the most negative value maps onto 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      // A zero divisor skips the iteration and goes straight to result formatting.
      LOAD: state_nxt = (dvs_q == '0) ? SIGN : CALC;
      CALC: if (count == CW'(WIDTH-1)) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign shl   = {acc, qr[WIDTH-1]};
  assign trial = shl - {1'b0, dvs_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q       <= dividend;
            dvs_q       <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        LOAD: begin
          acc         <= '0;
          qr          <= mag(dvd_q);
          dvs_mag     <= mag(dvs_q);
          sign_q      <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          sign_r      <= dvd_q[WIDTH-1];
          count       <= '0;
          div_by_zero <= (dvs_q == '0);
          overflow    <= (dvd_q == MINV) && (dvs_q == '1);
        end
        CALC: begin
          // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so shl never overflows.
          acc   <= trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
          qr    <= {qr[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + 1'b1;
        end
        SIGN: begin
          if (div_by_zero) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else begin
            quotient  <= cond_neg(qr, sign_q);
            remainder <= cond_neg(acc, sign_r);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
